// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the request/response memory port.
// Reads a word array with a fixed LATENCY and returns data in acceptance
// order. A host port preloads the array. Counters report in-flight requests
// and total responses.
// Optional build macro: MEM_RSP_STALL_EN adds LFSR-driven request backpressure.

package bronco_params;
    parameter int DATA_WIDTH = 16;
    parameter int ADDR_WIDTH = 16;
endpackage

module mem_responder #(
    parameter int DATA_WIDTH      = bronco_params::DATA_WIDTH,
    parameter int ADDR_WIDTH      = bronco_params::ADDR_WIDTH,
    parameter int DEPTH_LOG2      = 8,
    parameter int LATENCY         = 3,   // must be >= 1
    parameter int MAX_OUTSTANDING = 4    // must be 1..15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m_req_vld,
    output logic                  m_req_rdy,
    input  logic [ADDR_WIDTH-1:0] m_req_addr,
    output logic                  m_rsp_vld,
    output logic [DATA_WIDTH-1:0] m_rsp_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [3:0]            outstanding,
    output logic [15:0]           rsp_count
);

    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LATENCY-1:0]    vld_pipe;
    logic [DATA_WIDTH-1:0] data_pipe [LATENCY];
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  ready_en;
    logic                  stall;
    logic                  accept;
    logic                  rsp_issue;
    logic                  unused_addr_hi;

    // Addresses wrap modulo the array depth; upper bits are deliberately ignored.
    assign rd_idx         = m_req_addr[DEPTH_LOG2-1:0];
    assign wr_idx         = wr_addr[DEPTH_LOG2-1:0];
    assign unused_addr_hi = ^{m_req_addr[ADDR_WIDTH-1:DEPTH_LOG2],
                              wr_addr[ADDR_WIDTH-1:DEPTH_LOG2]};

`ifdef MEM_RSP_STALL_EN
    logic [7:0] lfsr;

    // Galois LFSR x^8+x^6+x^5+x^4+1 (right-shifting form, mask 8'hB8).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
        end
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Ready comes only from registered state so it never depends on m_req_vld.
    assign m_req_rdy = ready_en && (outstanding < MAX_OUT) && !stall;
    assign accept    = m_req_vld && m_req_rdy;

    // The array is read combinationally in the accept cycle. A write on the
    // same edge lands after this read, so the response carries the old word.
    assign rd_word = mem[rd_idx];

    // Host preload write; independent of the request path.
    // NOTE: storage arrays are left out of reset: contents must survive a
    // reset, and resetting every word would stop the array mapping to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Holds ready low during reset and releases it on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Response shift pipeline; data stages load only behind a valid bit so
    // the final stage (the output register) holds its last word when idle.
    // NOTE: clocked state uses non-blocking assignments so every stage samples
    // the previous stage's pre-edge value; blocking writes here would collapse
    // the shift chain into a single cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= accept;
            if (accept) begin
                data_pipe[0] <= rd_word;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) begin
                    data_pipe[i] <= data_pipe[i-1];
                end
            end
        end
    end

    assign m_rsp_vld  = vld_pipe[LATENCY-1];
    assign m_rsp_data = data_pipe[LATENCY-1];

    // A response is issued on the edge that loads the output stage.
    generate
        if (LATENCY == 1) begin : g_lat_one
            assign rsp_issue = accept;
        end else begin : g_lat_multi
            assign rsp_issue = vld_pipe[LATENCY-2];
        end
    endgenerate

    // In-flight count: up on accept, down on issue, unchanged when both occur.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= 4'd0;
        end else begin
            case ({accept, rsp_issue})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Total responses issued since reset, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_count <= 16'd0;
        end else if (rsp_issue && (rsp_count != 16'hFFFF)) begin
            rsp_count <= rsp_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a default instance and a throttled
// instance (MAX_OUTSTANDING=2) share clock, reset and the preload port.
// A queue-based reference model predicts every response, counter and ready.

module tb_mem_responder;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DL    = 8;
    localparam int LAT   = 3;
    localparam int MAXO  = 4;
    localparam int TMAXO = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          m_req_vld = 1'b0;
    logic          m_req_rdy;
    logic [AW-1:0] m_req_addr = '0;
    logic          m_rsp_vld;
    logic [DW-1:0] m_rsp_data;
    logic          t_req_vld = 1'b0;
    logic          t_req_rdy;
    logic [AW-1:0] t_req_addr = '0;
    logic          t_rsp_vld;
    logic [DW-1:0] t_rsp_data;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    outstanding;
    logic [3:0]    t_outstanding;
    logic [15:0]   rsp_count;
    logic [15:0]   t_rsp_count;

    always #5 clk = ~clk;

    mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL),
                    .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_addr(m_req_addr),
        .m_rsp_vld(m_rsp_vld), .m_rsp_data(m_rsp_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .outstanding(outstanding), .rsp_count(rsp_count)
    );

    mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL),
                    .LATENCY(LAT), .MAX_OUTSTANDING(TMAXO)) dut_thr (
        .clk(clk), .rst_n(rst_n),
        .m_req_vld(t_req_vld), .m_req_rdy(t_req_rdy), .m_req_addr(t_req_addr),
        .m_rsp_vld(t_rsp_vld), .m_rsp_data(t_rsp_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .outstanding(t_outstanding), .rsp_count(t_rsp_count)
    );

    // Reference model: each accepted request becomes {due cycle, word}.
    // A request accepted on edge k is answered on edge k+LAT-1 (LAT cycles
    // after the cycle it was presented in); until then it counts as in flight.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          q[$];
    rsp_t          tq[$];
    logic [DW-1:0] ref_mem [1<<DL];
    logic [DW-1:0] exp_d = '0;
    logic [DW-1:0] t_exp_d = '0;
    int            exp_cnt = 0;
    int            t_exp_cnt = 0;
    int            cyc = 0;
    bit            rdy_en = 1'b0;
    bit            last_acc = 1'b0;
    bit            last_tacc = 1'b0;
    logic [DW-1:0] obs[$];
    logic [DW-1:0] t_obs[$];
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_outputs();
        bit ev;
        bit tev;
        ev  = (q.size() > 0) && (q[0].due == cyc);
        tev = (tq.size() > 0) && (tq[0].due == cyc);
        if (ev) begin
            exp_d = q[0].data;
            q.delete(0);
            if (exp_cnt < 65535) exp_cnt++;
        end
        if (tev) begin
            t_exp_d = tq[0].data;
            tq.delete(0);
            if (t_exp_cnt < 65535) t_exp_cnt++;
        end
        check("rsp_vld",       32'(m_rsp_vld),     32'(ev));
        check("rsp_data",      32'(m_rsp_data),    32'(exp_d));
        check("outstanding",   32'(outstanding),   32'(q.size()));
        check("rsp_count",     32'(rsp_count),     32'(exp_cnt));
        check("req_rdy",       32'(m_req_rdy),     32'(rdy_en && (q.size() < MAXO)));
        check("t_rsp_vld",     32'(t_rsp_vld),     32'(tev));
        check("t_rsp_data",    32'(t_rsp_data),    32'(t_exp_d));
        check("t_outstanding", 32'(t_outstanding), 32'(tq.size()));
        check("t_rsp_count",   32'(t_rsp_count),   32'(t_exp_cnt));
        check("t_req_rdy",     32'(t_req_rdy),     32'(rdy_en && (tq.size() < TMAXO)));
        if (m_rsp_vld) obs.push_back(m_rsp_data);
        if (t_rsp_vld) t_obs.push_back(t_rsp_data);
    endtask

    // One clock: predict accepts from pre-edge inputs, advance, then compare.
    task automatic tick();
        bit            acc;
        bit            tacc;
        logic [DW-1:0] rd;
        logic [DW-1:0] trd;
        acc  = m_req_vld && rdy_en && (q.size() < MAXO);
        tacc = t_req_vld && rdy_en && (tq.size() < TMAXO);
        rd   = ref_mem[m_req_addr[DL-1:0]];
        trd  = ref_mem[t_req_addr[DL-1:0]];
        @(posedge clk);
        cyc++;
        if (acc)  q.push_back('{cyc + LAT - 1, rd});
        if (tacc) tq.push_back('{cyc + LAT - 1, trd});
        if (wr_en) ref_mem[wr_addr[DL-1:0]] = wr_data;
        rdy_en    = rst_n;
        last_acc  = acc;
        last_tacc = tacc;
        #1;
        compare_outputs();
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        q.delete();
        tq.delete();
        exp_d     = '0;
        t_exp_d   = '0;
        exp_cnt   = 0;
        t_exp_cnt = 0;
        rdy_en    = 1'b0;
        #1;
        compare_outputs();
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Single read on the default instance from idle, optionally with a write
    // in the same cycle; waits a bounded number of cycles for the response.
    task automatic req_one(input logic [AW-1:0] a, input bit do_wr,
                           input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                           output logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        d   = '0;
        m_req_vld = 1'b1; m_req_addr = a;
        wr_en = do_wr; wr_addr = wa; wr_data = wd;
        tick();
        m_req_vld = 1'b0; wr_en = 1'b0;
        if (m_rsp_vld) begin
            got = 1'b1;
            d   = m_rsp_data;
        end
        for (int w = 0; w < 10 && !got; w++) begin
            tick();
            if (m_rsp_vld) begin
                got = 1'b1;
                d   = m_rsp_data;
            end
        end
        check("req_one_response_seen", 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        int            base;
        int            lows;
        int            ta;

        // Reset: everything zero, ready low while reset is held.
        #1;
        assert_reset();
        tick();
        tick();
        check("reset_rdy_low", 32'(m_req_rdy), 32'd0);
        #3 rst_n = 1'b1;
        check("rdy_low_before_first_edge", 32'(m_req_rdy), 32'd0);
        tick();
        check("rdy_high_after_reset", 32'(m_req_rdy), 32'd1);

        // Fill the whole array with random words so the model knows every entry.
        for (int i = 0; i < (1 << DL); i++) begin
            write_word(AW'(i), DW'($urandom));
        end

        // Preload then single read: in flight for two cycles, then the response.
        write_word(16'd5, 16'h1234);
        m_req_vld = 1'b1; m_req_addr = 16'd5;
        tick();
        m_req_vld = 1'b0;
        check("pre_outstanding_1", 32'(outstanding), 32'd1);
        tick();
        check("pre_outstanding_2", 32'(outstanding), 32'd1);
        tick();
        check("pre_rsp_vld", 32'(m_rsp_vld), 32'd1);
        check("pre_rsp_data", 32'(m_rsp_data), 32'h1234);
        tick();
        check("pre_data_hold", 32'(m_rsp_data), 32'h1234);

        // Burst: eight back-to-back requests, eight consecutive responses.
        for (int i = 0; i < 8; i++) write_word(AW'(i), DW'(i + 1));
        base = exp_cnt;
        obs.delete();
        for (int i = 0; i < 8; i++) begin
            m_req_vld = 1'b1; m_req_addr = AW'(i);
            check("burst_rdy", 32'(m_req_rdy), 32'd1);
            tick();
        end
        m_req_vld = 1'b0;
        repeat (LAT + 1) tick();
        check("burst_n_rsp", 32'(obs.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < obs.size()) check("burst_data", 32'(obs[i]), 32'(i + 1));
        end
        check("burst_rsp_count", 32'(rsp_count), 32'(base + 8));

        // Throttle: continuous requests into MAX_OUTSTANDING=2, LATENCY=3.
        t_obs.delete();
        lows = 0;
        ta   = 0;
        for (int i = 0; i < 12; i++) begin
            t_req_vld = 1'b1; t_req_addr = AW'(ta);
            if (!t_req_rdy) lows++;
            tick();
            if (last_tacc) ta++;
        end
        t_req_vld = 1'b0;
        repeat (LAT + 1) tick();
        check("thr_rdy_low_cycles", 32'(lows), 32'd4);
        check("thr_n_rsp", 32'(t_obs.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < t_obs.size()) check("thr_data", 32'(t_obs[i]), 32'(i + 1));
        end

        // Wrap: address 0x103 aliases index 3.
        write_word(16'h0003, 16'h00AA);
        req_one(16'h0103, 1'b0, '0, '0, d);
        check("wrap_data", 32'(d), 32'h00AA);
        // Collision: read and write of index 3 on the same edge returns old data.
        req_one(16'h0003, 1'b1, 16'h0003, 16'h0055, d);
        check("collision_old", 32'(d), 32'h00AA);
        req_one(16'h0003, 1'b0, '0, '0, d);
        check("collision_new", 32'(d), 32'h0055);
        repeat (2) tick();

        // Reset mid-flight: two requests in flight are dropped silently.
        obs.delete();
        for (int i = 0; i < 2; i++) begin
            m_req_vld = 1'b1; m_req_addr = AW'(i);
            tick();
        end
        m_req_vld = 1'b0;
        check("inflight_before_reset", 32'(outstanding), 32'd2);
        assert_reset();
        tick();
        tick();
        #3 rst_n = 1'b1;
        repeat (6) tick();
        check("no_rsp_after_reset", 32'(obs.size()), 32'd0);
        check("count_after_reset", 32'(rsp_count), 32'd0);
        req_one(16'h0001, 1'b0, '0, '0, d);
        check("array_retained", 32'(d), 32'h0002);

        // Randomized traffic on both instances with random preload writes.
        m_req_vld = 1'b0;
        t_req_vld = 1'b0;
        last_acc  = 1'b0;
        last_tacc = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!m_req_vld || last_acc) begin
                m_req_vld  = ($urandom_range(0, 3) != 0);
                m_req_addr = AW'($urandom);
            end
            if (!t_req_vld || last_tacc) begin
                t_req_vld  = ($urandom_range(0, 3) != 0);
                t_req_addr = AW'($urandom);
            end
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom);
            wr_data = DW'($urandom);
            tick();
        end
        m_req_vld = 1'b0;
        t_req_vld = 1'b0;
        wr_en     = 1'b0;
        repeat (LAT + 2) tick();
        check("final_idle", 32'(outstanding), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
